counter_mod_n_down: RTL and testbench



---
 rtl/counter_mod_n_down_pkg.sv | 14 +
 rtl/counter_mod_n_down_core.sv | 31 +++
 rtl/counter_mod_n_down.sv | 83 ++++++++
 tb/tb_counter_mod_n_down.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mod_n_down_pkg.sv
// Shared types and constants for the modulo-N down-counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_mod_n_down_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/counter_mod_n_down_core.sv
// Down-count register with load, decrement and hold, plus a zero flag.
// Latency: load/decrement visible one clock after the edge; zero flag is combinational from the register.
// Backpressure: none; hold whenever neither load nor dec is asserted.
module down_count_core
   import counter_mod_n_down_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock_pos,
   input  logic             reset_neg,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   // Count register: load wins over decrement; otherwise hold.
   always_ff @(posedge clock_pos or negedge reset_neg) begin
      if (!reset_neg) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/counter_mod_n_down.sv
// Programmable modulo-N down-counter with reload register and terminal-count strobe.
// Latency: count, strobe and busy are registered; strobe appears the cycle after the enabled edge that saw zero.
// Backpressure: bit_enable low freezes the count; load always takes effect and overrides everything else.
module counter_mod_n_down
   import counter_mod_n_down_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter bit AUTO_RELOAD = 1'b1
) (
   input  logic             clock_pos,
   input  logic             reset_neg,
   input  logic             bit_load,
   input  logic [WIDTH-1:0] vector_period,
   input  logic             bit_enable,
   output logic [WIDTH-1:0] vector_out,
   output logic             bit_terminal,
   output logic             bit_busy
);

   state_t           state;
   logic [WIDTH-1:0] reload;
   logic             zero;
   logic             run_en;
   logic             tc_hit;
   logic             core_load;
   logic [WIDTH-1:0] core_value;
   logic             core_dec;

   // An enabled RUN edge only counts when no load is competing for it.
   assign run_en     = (state == ST_RUN) && bit_enable && !bit_load;
   assign tc_hit     = run_en && zero;
   assign core_load  = bit_load || (tc_hit && AUTO_RELOAD);
   assign core_value = bit_load ? vector_period : reload;
   assign core_dec   = run_en && !zero;

   down_count_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock_pos  (clock_pos),
      .reset_neg  (reset_neg),
      .load       (core_load),
      .load_value (core_value),
      .dec        (core_dec),
      .count      (vector_out),
      .zero       (zero)
   );

   // Control FSM with reload register, one-cycle terminal strobe and registered busy.
   always_ff @(posedge clock_pos or negedge reset_neg) begin
      if (!reset_neg) begin
         state        <= ST_IDLE;
         reload       <= '0;
         bit_terminal <= 1'b0;
         bit_busy     <= 1'b0;
      end else if (bit_load) begin
         reload       <= vector_period;
         state        <= ST_RUN;
         bit_terminal <= 1'b0;
         bit_busy     <= 1'b1;
      end else begin
         bit_terminal <= 1'b0;
         case (state)
            ST_RUN: begin
               if (tc_hit) begin
                  bit_terminal <= 1'b1;
                  if (!AUTO_RELOAD) begin
                     state    <= ST_DONE;
                     bit_busy <= 1'b0;
                  end
               end
            end
            ST_IDLE, ST_DONE: begin
               state <= state;
            end
            default: begin
               state    <= ST_IDLE;
               bit_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_mod_n_down.sv
// Bench for counter_mod_n_down: periodic and one-shot instances driven in lockstep.
// Latency: expectations pushed at drive time, popped one edge later.
// Backpressure: n/a.
module tb_counter_mod_n_down;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] out;
      logic         term;
      logic         busy;
   } exp_t;

   logic         clock_pos;
   logic         reset_neg;
   logic         bit_load;
   logic [W-1:0] vector_period;
   logic         bit_enable;
   logic [W-1:0] out_p, out_o;
   logic         term_p, term_o, busy_p, busy_o;

   int tests_run = 0;
   int tests_failed = 0;

   exp_t q_p[$];
   exp_t q_o[$];

   // reference models: [0] periodic, [1] one-shot
   logic [1:0]   m_st  [2];
   logic [W-1:0] m_rel [2];
   logic [W-1:0] m_out [2];
   logic         m_term[2];

   counter_mod_n_down #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_p (
      .clock_pos     (clock_pos),
      .reset_neg     (reset_neg),
      .bit_load      (bit_load),
      .vector_period (vector_period),
      .bit_enable    (bit_enable),
      .vector_out    (out_p),
      .bit_terminal  (term_p),
      .bit_busy      (busy_p)
   );

   counter_mod_n_down #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_o (
      .clock_pos     (clock_pos),
      .reset_neg     (reset_neg),
      .bit_load      (bit_load),
      .vector_period (vector_period),
      .bit_enable    (bit_enable),
      .vector_out    (out_o),
      .bit_terminal  (term_o),
      .bit_busy      (busy_o)
   );

   initial clock_pos = 1'b0;
   always #5 clock_pos = ~clock_pos;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model_exp(input int i);
      exp_t e;
      e.out  = m_out[i];
      e.term = m_term[i];
      e.busy = (m_st[i] == 2'b01);
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i]   = 2'b00;
         m_rel[i]  = '0;
         m_out[i]  = '0;
         m_term[i] = 1'b0;
      end
   endtask

   // Reference behaviour for one clock edge.
   task automatic model_edge(input logic ld, input logic [W-1:0] per, input logic en);
      for (int i = 0; i < 2; i++) begin
         if (ld) begin
            m_rel[i]  = per;
            m_out[i]  = per;
            m_st[i]   = 2'b01;
            m_term[i] = 1'b0;
         end else if (m_st[i] == 2'b01 && en) begin
            if (m_out[i] != 0) begin
               m_out[i]  = m_out[i] - 1'b1;
               m_term[i] = 1'b0;
            end else begin
               m_term[i] = 1'b1;
               if (i == 0) m_out[i] = m_rel[i];
               else        m_st[i]  = 2'b10;
            end
         end else begin
            m_term[i] = 1'b0;
         end
      end
   endtask

   task automatic push_exp();
      q_p.push_back(model_exp(0));
      q_o.push_back(model_exp(1));
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (q_p.size() == 0 || q_o.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
         return;
      end
      e = q_p.pop_front();
      check({tag, "_p_out"},  32'(out_p),  32'(e.out));
      check({tag, "_p_term"}, 32'(term_p), 32'(e.term));
      check({tag, "_p_busy"}, 32'(busy_p), 32'(e.busy));
      e = q_o.pop_front();
      check({tag, "_o_out"},  32'(out_o),  32'(e.out));
      check({tag, "_o_term"}, 32'(term_o), 32'(e.term));
      check({tag, "_o_busy"}, 32'(busy_o), 32'(e.busy));
   endtask

   task automatic step(input string tag, input logic ld, input logic [W-1:0] per, input logic en);
      @(negedge clock_pos);
      bit_load      = ld;
      vector_period = per;
      bit_enable    = en;
      model_edge(ld, per, en);
      push_exp();
      @(posedge clock_pos);
      #1;
      compare(tag);
   endtask

   // Drop reset between edges and check outputs without any clock edge.
   task automatic async_reset(input string tag);
      @(posedge clock_pos);
      #3;
      reset_neg = 1'b0;
      model_reset();
      push_exp();
      #1;
      compare(tag);
      @(negedge clock_pos);
      bit_load  = 1'b0;
      reset_neg = 1'b1;
   endtask

   initial begin
      int gap;
      bit seen;
      reset_neg     = 1'b0;
      bit_load      = 1'b0;
      vector_period = '0;
      bit_enable    = 1'b0;
      model_reset();
      #12;
      push_exp();
      compare("reset");
      @(negedge clock_pos);
      reset_neg = 1'b1;

      // idle ignores enable
      step("idle", 1'b0, 4'd9, 1'b1);
      step("idle", 1'b0, 4'd9, 1'b1);

      // periodic count from 3; one-shot instance stops at DONE
      step("load3", 1'b1, 4'd3, 1'b1);
      for (int k = 0; k < 10; k++) step("per3", 1'b0, W'($urandom), 1'b1);

      // enable gating
      step("load5", 1'b1, 4'd5, 1'b1);
      step("gate", 1'b0, 4'd0, 1'b1);
      step("gate", 1'b0, 4'd0, 1'b0);
      step("gate", 1'b0, 4'd0, 1'b0);
      step("gate", 1'b0, 4'd0, 1'b1);
      step("gate", 1'b0, 4'd0, 1'b1);

      // one-shot from 2, then restart with 1
      step("load2", 1'b1, 4'd2, 1'b1);
      for (int k = 0; k < 5; k++) step("shot2", 1'b0, 4'd12, 1'b1);
      step("load1", 1'b1, 4'd1, 1'b0);
      for (int k = 0; k < 4; k++) step("shot1", 1'b0, 4'd12, 1'b1);

      // load colliding with terminal count
      step("load1c", 1'b1, 4'd1, 1'b1);
      step("dec0", 1'b0, 4'd0, 1'b1);
      step("collide", 1'b1, 4'd7, 1'b1);
      step("after", 1'b0, 4'd0, 1'b1);

      // R = 0: strobe every enabled cycle
      step("load0", 1'b1, 4'd0, 1'b1);
      for (int k = 0; k < 5; k++) step("r0", 1'b0, 4'd3, 1'b1);
      async_reset("rst_strobe");

      // R = 15: 16 enabled edges between strobes
      step("load15", 1'b1, 4'd15, 1'b1);
      gap  = 0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step("r15", 1'b0, W'($urandom), 1'b1);
         gap++;
         if (term_p) begin
            if (seen) check("r15_period", 32'(gap), 32'd16);
            seen = 1'b1;
            gap  = 0;
         end
      end

      // random mix
      for (int k = 0; k < 200; k++)
         step("rand", ($urandom_range(0, 15) == 0), W'($urandom), 1'($urandom));

      // mid-run reset
      step("load9", 1'b1, 4'd9, 1'b1);
      step("run9", 1'b0, 4'd0, 1'b1);
      step("run9", 1'b0, 4'd0, 1'b1);
      async_reset("rst_mid");
      step("post_rst", 1'b0, 4'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
